// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INSTR  = 32'h0000_0000;
    localparam int          FETCH_Q_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus8;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry queue of fetched instructions; clear beats push
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [FETCH_Q_DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is two, so a single toggling bit is a complete pointer.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
            if (i_push && !w_pop) begin
                assert (r_count < 2'(FETCH_Q_DEPTH))
                    else $error("fetch_fifo overflow");
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, single-outstanding imem requests, redirect handling and IF/ID register
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] InstrD,
    output logic        InstrValidD,
    output logic [31:0] PCPlus8D
);

    fetch_state_t r_state;
    logic [31:0]  r_pcf;
    logic [31:0]  r_pend_pc;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_resp;
    logic         w_deliver;
    logic         w_pop;
    logic         w_bypass;
    logic         w_push;
    logic         w_room;
    logic         w_issue;
    logic [1:0]   w_count;
    logic [1:0]   w_count_next;
    fetch_entry_t w_head;
    fetch_entry_t w_resp_entry;

    assign w_redirect   = BranchTakenE | PCSrcW;
    assign w_target     = BranchTakenE ? ALUResultE : ResultW;
    assign w_resp       = (r_state == WAIT) && IMemValid && !w_redirect;
    assign w_resp_entry = '{instr: IMemRData, pcplus8: r_pend_pc + 32'd8};

    // A response goes straight to IF/ID only when nothing older is queued.
    assign w_deliver = !FlushD && !StallD;
    assign w_pop     = w_deliver && (w_count != 2'd0);
    assign w_bypass  = w_deliver && (w_count == 2'd0) && w_resp;
    assign w_push    = w_resp && !w_bypass;

    always_comb begin
        w_count_next = w_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_redirect) begin
            w_count_next = 2'd0;
        end
    end

    assign w_room = w_count_next < 2'(FETCH_Q_DEPTH);

    always_comb begin
        w_issue = 1'b0;
        if (!Reset && !w_redirect && w_room) begin
            case (r_state)
                IDLE:    w_issue = 1'b1;
                WAIT:    w_issue = IMemValid;
                default: w_issue = 1'b0;
            endcase
        end
    end

    assign IMemReq  = w_issue;
    assign IMemAddr = r_pcf;

    fetch_fifo u_fifo (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  (w_resp_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pcf     <= RESET_PC;
            r_pend_pc <= 32'h0;
        end else begin
            if (w_redirect) begin
                r_pcf <= w_target;
            end else if (w_issue) begin
                r_pcf <= r_pcf + 32'd4;
            end
            if (w_issue) begin
                r_pend_pc <= r_pcf;
            end
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (IMemValid) begin
                        r_state <= w_issue ? WAIT : IDLE;
                    end else if (w_redirect) begin
                        r_state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (IMemValid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset || FlushD) begin
            InstrD      <= BUBBLE_INSTR;
            InstrValidD <= 1'b0;
            PCPlus8D    <= 32'h0;
        end else if (!StallD) begin
            if (w_count != 2'd0) begin
                InstrD      <= w_head.instr;
                InstrValidD <= 1'b1;
                PCPlus8D    <= w_head.pcplus8;
            end else if (w_resp) begin
                InstrD      <= w_resp_entry.instr;
                InstrValidD <= 1'b1;
                PCPlus8D    <= w_resp_entry.pcplus8;
            end else begin
                InstrD      <= BUBBLE_INSTR;
                InstrValidD <= 1'b0;
                PCPlus8D    <= 32'h0;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined ARM core. Owns the PC, issues single-outstanding requests to instruction memory, buffers returned words in a 2-entry queue, and drives the IF/ID register whose `InstrD` feeds the decode-stage control unit. It also absorbs branch/PC-write redirects and discards stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `CLK`  in  1  system clock; all state on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `IMemReq`  out  1  one-cycle request strobe.
- `IMemAddr`  out  32  word address of the request; valid while `IMemReq`=1.
- `IMemValid`  in  1  response strobe; latency ≥1 cycle after `IMemReq`.
- `IMemRData`  in  32  instruction word, valid with `IMemValid`.
- `StallD`  in  1  hold IF/ID register.
- `FlushD`  in  1  load a bubble into IF/ID; overrides `StallD`.
- `BranchTakenE`  in  1  redirect to `ALUResultE`.
- `ALUResultE`  in  32  branch target.
- `PCSrcW`  in  1  redirect to `ResultW` (write to R15).
- `ResultW`  in  32  PC-write target.
- `InstrD`  out  32  instruction to decode / control unit.
- `InstrValidD`  out  1  `InstrD` is a real instruction.
- `PCPlus8D`  out  32  fetch address + 8, for R15 reads in decode.

## Operation
- Reset: `PCF`=`RESET_PC`, state IDLE, queue empty, `InstrD`=0, `InstrValidD`=0, `PCPlus8D`=0, `IMemReq`=0.
- Redirect = `BranchTakenE | PCSrcW`; target = `BranchTakenE ? ALUResultE : ResultW` (`BranchTakenE` wins). On redirect: `PCF`←target, queue cleared, no request issued that cycle.
- Room = (queue count after this cycle's pop/push) < 2. `IMemReq`=1 when room, no redirect, and state allows issue. On issue: `IMemAddr`=`PCF`, `PendPC`←`PCF`, `PCF`←`PCF`+4.
- FSM:
  - IDLE: issue → WAIT; redirect → stay IDLE.
  - WAIT: `IMemValid`, no redirect → push {`IMemRData`, `PendPC`+8}; if room, issue again and stay WAIT, else → IDLE. Redirect with `IMemValid` → drop word, IDLE. Redirect without `IMemValid` → DISCARD.
  - DISCARD: `IMemValid` → drop word, IDLE; no issue in DISCARD. A further redirect updates `PCF` only.
- IF/ID register: `FlushD` → `InstrD`=0, `InstrValidD`=0, `PCPlus8D`=0. Else if `!StallD`: pop head, or bypass the arriving response when the queue is empty; if neither is available, load a bubble. `StallD` alone holds all three outputs.
- Ordering: instructions reach `InstrD` strictly in fetch-address order. The queue never exceeds 2 entries; an overflow is an assertion failure.

## Timing
- `IMemReq`/`IMemAddr` are combinational from state, `PCF`, and queue count. All other outputs are registered.
- With 1-cycle memory: reset released before cycle 0 → request at cycle 0, response at cycle 1, first `InstrD` valid at cycle 2. Sustained throughput is 1 instruction per cycle with no stalls.
- Redirect in cycle n → first request to the target in cycle n+1 if not in DISCARD. The target instruction is in `InstrD` at n+3 with 1-cycle memory.
- Response arriving in the same cycle as a redirect is always dropped.
- Reset mid-request: the state returns to IDLE, and any later `IMemValid` before the next issue is ignored (IDLE ignores `IMemValid`).

## Structure
- `fetch_pkg`: `fetch_state_t` enum {IDLE, WAIT, DISCARD}, `BUBBLE_INSTR`=32'h0, queue depth constant 2, `fetch_entry_t` struct {instr[31:0], pcplus8[31:0]}.
- Sub-module `fetch_fifo`: 2-entry queue of `fetch_entry_t`. Signals: push, pop, clear, head, count. Clear has priority over push.
- The IF/ID register and FSM live in `fetch_stage`.

## Test plan
- Reset release, 1-cycle memory returning `addr`-derived words, no stalls → `IMemAddr` 0,4,8,…; `InstrD` sequence from cycle 2 with `PCPlus8D` 8,12,16…; no bubbles.
- `StallD` high cycles 5–7 → `InstrD` held; queue fills to 2; `IMemReq` low while full; order preserved after release, no word lost or duplicated.
- `BranchTakenE`=1, `ALUResultE`=0x100 while a request is outstanding and memory latency is 3 → stale word dropped (DISCARD). Next `IMemAddr`=0x100; `InstrD` from 0x100 with `PCPlus8D`=0x108.
- `BranchTakenE` and `PCSrcW` both high in the same cycle, targets 0x200/0x300 → fetch resumes at 0x200.
- `FlushD` and `StallD` both high → `InstrValidD`=0, `InstrD`=0 next cycle.
- `Reset` asserted while in WAIT, late `IMemValid` arrives → ignored; fetch restarts at `RESET_PC`, and the first `InstrD` is the word from `RESET_PC`.
